fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 104 ++++++++++
 tb/tb_fetch_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid
// buffer that catches a fetch completing while decode is stalled.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc_plus4;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        unused_lo;

  assign pc_plus4  = pc + 32'd4;
  assign target    = {redirect_pc[31:2], 2'b00};
  assign unused_lo = &{1'b0, redirect_pc[1:0]};

  // Request and address come straight from registers: no input-to-address path.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      pc             <= RST_PC;
      buf_instr      <= 32'h0;
      buf_pc_plus4   <= 32'h0;
      if_id_instr    <= 32'h0;
      if_id_pc_plus4 <= 32'h0;
      if_id_valid    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (!stall) begin
            if (redirect) begin
              pc             <= target;
              if_id_instr    <= 32'h0;
              if_id_pc_plus4 <= 32'h0;
              if_id_valid    <= 1'b0;
            end else if (imem_ready) begin
              pc             <= pc_plus4;
              if_id_instr    <= imem_rdata;
              if_id_pc_plus4 <= pc_plus4;
              if_id_valid    <= 1'b1;
            end else begin
              if_id_instr    <= 32'h0;
              if_id_pc_plus4 <= 32'h0;
              if_id_valid    <= 1'b0;
            end
          end else if (imem_ready) begin
            // Fetch landed during a stall: park it until decode can take it.
            buf_instr    <= imem_rdata;
            buf_pc_plus4 <= pc_plus4;
            pc           <= pc_plus4;
            state        <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (!stall) begin
            state <= S_FETCH;
            if (redirect) begin
              pc             <= target;
              buf_instr      <= 32'h0;
              buf_pc_plus4   <= 32'h0;
              if_id_instr    <= 32'h0;
              if_id_pc_plus4 <= 32'h0;
              if_id_valid    <= 1'b0;
            end else begin
              if_id_instr    <= buf_instr;
              if_id_pc_plus4 <= buf_pc_plus4;
              if_id_valid    <= 1'b1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with fixed expectations, then
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A reads as A|1.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a | 32'h1;
  endfunction
  assign imem_rdata = mem(imem_addr);

  wire [97:0] obs = {imem_req, imem_addr, if_id_instr, if_id_pc_plus4, if_id_valid};

  // Reference model: a started flag, the next address to fetch, an optional
  // parked instruction, and the IF/ID contents.
  bit          m_started;
  bit          m_parked;
  logic [31:0] m_pc, m_pk_i, m_pk_p, m_i, m_p;
  bit          m_v;

  function automatic logic [97:0] model_obs();
    return {(m_started && !m_parked), m_pc, m_i, m_p, m_v};
  endfunction

  task automatic model_reset();
    m_started = 0; m_parked = 0; m_pc = 32'h0;
    m_pk_i = 0; m_pk_p = 0; m_i = 0; m_p = 0; m_v = 0;
  endtask

  task automatic model_step(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
    logic [31:0] tgt;
    tgt = rp & 32'hFFFF_FFFC;
    if (!m_started) m_started = 1;
    else if (m_parked) begin
      if (!s) begin
        m_parked = 0;
        if (r) begin m_pc = tgt; m_i = 0; m_p = 0; m_v = 0; end
        else begin m_i = m_pk_i; m_p = m_pk_p; m_v = 1; end
      end
    end else if (!s) begin
      if (r) begin m_pc = tgt; m_i = 0; m_p = 0; m_v = 0; end
      else if (rdy) begin m_i = mem(m_pc); m_p = m_pc + 4; m_v = 1; m_pc = m_pc + 4; end
      else begin m_i = 0; m_p = 0; m_v = 0; end
    end else if (rdy) begin
      m_pk_i = mem(m_pc); m_pk_p = m_pc + 4; m_pc = m_pc + 4; m_parked = 1;
    end
  endtask

  // Drive one cycle of inputs, advance the model, settle 1ns after the edge.
  task automatic tick(input bit s, input bit r, input logic [31:0] rp, input bit rdy);
    stall = s; redirect = r; redirect_pc = rp; imem_ready = rdy;
    model_step(s, r, rp, rdy);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    @(posedge clk); #1;
    checks++;
    if (obs !== 98'h0) begin errors++; $display("FAIL reset_state got %h exp %h", obs, 98'h0); end
    rst_n = 1;
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h0, 32'h0, 32'h0, 1'b0})
      begin errors++; $display("FAIL first_req got %h", obs); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 1);
      checks++;
      if (obs !== {1'b1, 32'(4*i+4), 32'(4*i+1), 32'(4*i+4), 1'b1})
        begin errors++; $display("FAIL stream_%0d got %h", i, obs); end
    end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0);
      checks++;
      if (obs !== {1'b1, 32'h8, 32'h0, 32'h0, 1'b0})
        begin errors++; $display("FAIL wait_bubble_%0d got %h", i, obs); end
    end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'hC, 32'h9, 32'hC, 1'b1})
      begin errors++; $display("FAIL wait_deliver got %h", obs); end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h10, 32'hD, 32'h10, 1'b1})
      begin errors++; $display("FAIL pre_stall got %h", obs); end
  endtask

  task automatic test_stall_skid();
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0, 1);
      checks++;
      if (obs !== {1'b0, 32'h14, 32'hD, 32'h10, 1'b1})
        begin errors++; $display("FAIL stall_hold_%0d got %h", i, obs); end
    end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h14, 32'h11, 32'h14, 1'b1})
      begin errors++; $display("FAIL skid_release got %h", obs); end
  endtask

  task automatic test_redirect();
    tick(0, 1, 32'h1003, 1);
    checks++;
    if (obs !== {1'b1, 32'h1000, 32'h0, 32'h0, 1'b0})
      begin errors++; $display("FAIL redirect_bubble got %h", obs); end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h1004, 32'h1001, 32'h1004, 1'b1})
      begin errors++; $display("FAIL redirect_target got %h", obs); end
    tick(1, 1, 32'h2000, 0);
    checks++;
    if (obs !== {1'b1, 32'h1004, 32'h1001, 32'h1004, 1'b1})
      begin errors++; $display("FAIL redirect_under_stall got %h", obs); end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h1008, 32'h1005, 32'h1008, 1'b1})
      begin errors++; $display("FAIL after_ignored_redirect got %h", obs); end
  endtask

  task automatic test_wrap();
    tick(0, 1, 32'hFFFF_FFFC, 1);
    checks++;
    if (obs !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0})
      begin errors++; $display("FAIL wrap_redirect got %h", obs); end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h0, 32'hFFFF_FFFD, 32'h0, 1'b1})
      begin errors++; $display("FAIL wrap_pc4 got %h", obs); end
  endtask

  task automatic test_async_reset_hold();
    tick(1, 0, 0, 1);
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL enter_hold req=%b exp 0", imem_req); end
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs !== 98'h0) begin errors++; $display("FAIL async_reset got %h exp 0", obs); end
    model_reset();
    stall = 0;
    @(posedge clk); #1 rst_n = 1;
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h0, 32'h0, 32'h0, 1'b0})
      begin errors++; $display("FAIL restart_req got %h", obs); end
    tick(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b1, 32'h4, 32'h1, 32'h4, 1'b1})
      begin errors++; $display("FAIL restart_first got %h", obs); end
  endtask

  task automatic test_random();
    bit s, r, rdy;
    logic [31:0] rp;
    int bad = 0;
    for (int n = 0; n < 400; n++) begin
      s   = ($urandom_range(0, 99) < 25);
      r   = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 75);
      rp  = $urandom;
      tick(s, r, rp, rdy);
      checks++;
      if (obs !== model_obs()) begin
        errors++;
        if (bad++ < 10) $display("FAIL random_%0d got %h exp %h", n, obs, model_obs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall_skid();
    test_redirect();
    test_wrap();
    test_async_reset_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
